rx_display: RTL and testbench

RX_DISPLAY -- requirements
Module: rx_display

---
 rtl/rx_display.sv | 138 +++++++++++++
 tb/tb_rx_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_display.sv
// Recovers a 3-digit value by snooping a multiplexed 7-segment display scan (U -> D -> C).
// Optional stall timeout enabled by defining RX_DISPLAY_TIMEOUT_EN.
module rx_display #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] enable,
  input  logic [6:0] segmentos,
  output logic [4:0] u,
  output logic [4:0] d,
  output logic [4:0] c,
  output logic       valid,
  output logic       err
);

  localparam logic [4:0] BLANK = 5'b10001;

  typedef enum logic [1:0] {SYNC, WAIT_D, WAIT_C, WAIT_U} state_t;

  state_t     state, state_nx;
  logic [2:0] en_s;
  logic [6:0] seg_s;
  logic [4:0] u_cap, d_cap;
  logic       frame_bad;

  logic [4:0] code;
  logic       code_bad;
  logic       slot_u, slot_d, slot_c, idle, proto_err;
  logic       cap_u, cap_d, cap_c, seq_err;
  logic       frame_bad_now, pub_ok, pub_bad;
  logic       tmo, tmo_err;

  always_comb begin
    code     = BLANK;
    code_bad = 1'b0;
    case (seg_s)
      7'h3F: code = 5'd0;
      7'h06: code = 5'd1;
      7'h5B: code = 5'd2;
      7'h4F: code = 5'd3;
      7'h66: code = 5'd4;
      7'h6D: code = 5'd5;
      7'h7D: code = 5'd6;
      7'h07: code = 5'd7;
      7'h7F: code = 5'd8;
      7'h6F: code = 5'd9;
      7'h00: code = BLANK;
      default: code_bad = 1'b1;
    endcase
  end

  assign slot_u    = (en_s == 3'b001);
  assign slot_d    = (en_s == 3'b010);
  assign slot_c    = (en_s == 3'b100);
  assign idle      = (en_s == 3'b000);
  assign proto_err = !(slot_u || slot_d || slot_c || idle);

  // A held slot keeps the FSM in the state it moved to, so only the first cycle captures.
  always_comb begin
    state_nx = state;
    cap_u    = 1'b0;
    cap_d    = 1'b0;
    cap_c    = 1'b0;
    seq_err  = 1'b0;
    if (proto_err) begin
      seq_err = 1'b1;
    end else begin
      case (state)
        SYNC:   cap_u = slot_u;
        WAIT_D: begin cap_d = slot_d; seq_err = slot_c; end
        WAIT_C: begin cap_c = slot_c; seq_err = slot_u; end
        WAIT_U: begin cap_u = slot_u; seq_err = slot_d; end
        default: ;
      endcase
    end
    if (cap_u)        state_nx = WAIT_D;
    else if (cap_d)   state_nx = WAIT_C;
    else if (cap_c)   state_nx = WAIT_U;
    else if (seq_err) state_nx = SYNC;
    if (tmo)          state_nx = SYNC;
  end

`ifdef RX_DISPLAY_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo     = !(cap_u || cap_d || cap_c) && (tmo_cnt == 16'(TIMEOUT - 1));
  assign tmo_err = tmo && (state != SYNC);

  always_ff @(posedge clk) begin
    if (reset || cap_u || cap_d || cap_c || tmo) tmo_cnt <= '0;
    else                                         tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign tmo     = 1'b0;
  assign tmo_err = 1'b0;
`endif

  assign frame_bad_now = frame_bad || code_bad;
  assign pub_ok        = cap_c && !frame_bad_now;
  assign pub_bad       = cap_c && frame_bad_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_s      <= '0;
      seg_s     <= '0;
      state     <= SYNC;
      u_cap     <= BLANK;
      d_cap     <= BLANK;
      frame_bad <= 1'b0;
      u         <= BLANK;
      d         <= BLANK;
      c         <= BLANK;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      en_s  <= enable;
      seg_s <= segmentos;
      state <= state_nx;
      valid <= pub_ok;
      err   <= seq_err || pub_bad || tmo_err;
      if (cap_u) begin
        u_cap     <= code;
        frame_bad <= code_bad;
      end
      if (cap_d) begin
        d_cap     <= code;
        frame_bad <= frame_bad_now;
      end
      if (pub_ok) begin
        u <= u_cap;
        d <= d_cap;
        c <= code;
      end
    end
  end

endmodule

// File: tb/tb_rx_display.sv
// Scoreboard bench for rx_display: expected publishes/errors queued at stimulus time, popped on pulses.
module tb_rx_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] enable = 3'b000;
  logic [6:0] segmentos = 7'h00;
  logic [4:0] u, d, c;
  logic       valid, err;

  rx_display #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .segmentos(segmentos),
    .u(u), .d(d), .c(c), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [4:0] eu, ed, ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [6:0] seg_of(int dg);
    case (dg)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [4:0] code_of(int dg);
    if (dg < 0) return 5'b10001;
    return 5'(dg);
  endfunction

  function automatic exp_t exp_valid(int a, int b, int cc);
    exp_t e;
    e.is_err = 1'b0; e.eu = code_of(a); e.ed = code_of(b); e.ec = code_of(cc);
    return e;
  endfunction

  function automatic exp_t exp_err();
    exp_t e;
    e.is_err = 1'b1; e.eu = '0; e.ed = '0; e.ec = '0;
    return e;
  endfunction

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (valid || err)) begin
      vectors++;
      if (valid && err) begin
        miscompares++;
        $display("FAIL pulse_overlap: valid=%b err=%b, required not both high", valid, err);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: valid=%b err=%b at %0t, required none", valid, err, $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_err !== err ||
            (!mon_e.is_err && {u, d, c} !== {mon_e.eu, mon_e.ed, mon_e.ec})) begin
          miscompares++;
          $display("FAIL pulse_content: err=%b u/d/c=%h/%h/%h, required err=%b u/d/c=%h/%h/%h",
                   err, u, d, c, mon_e.is_err, mon_e.eu, mon_e.ed, mon_e.ec);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] en, input logic [6:0] seg, input int n);
    repeat (n) begin
      @(negedge clk);
      enable = en;
      segmentos = seg;
    end
  endtask

  task automatic frame(input int a, input int b, input int cc, input int hold, input bit bad_d);
    drive(3'b001, seg_of(a), hold);
    drive(3'b010, bad_d ? 7'h7A : seg_of(b), hold);
    if (bad_d) sb.push_back(exp_err());
    else       sb.push_back(exp_valid(a, b, cc));
    drive(3'b100, seg_of(cc), hold);
    drive(3'b000, 7'h00, 2);
  endtask

  task automatic check_outs(input string name, input int a, input int b, input int cc);
    vectors++;
    if ({u, d, c} !== {code_of(a), code_of(b), code_of(cc)}) begin
      miscompares++;
      $display("FAIL %s: u/d/c=%h/%h/%h, required %h/%h/%h", name, u, d, c,
               code_of(a), code_of(b), code_of(cc));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_outs("reset_outputs", -1, -1, -1);
    vectors++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: valid=%b err=%b, required 0 0", valid, err);
    end
  endtask

  task automatic test_basic();
    sb.push_back(exp_valid(4, 3, 1));
    drive(3'b001, 7'h66, 1);
    drive(3'b010, 7'h4F, 1);
    drive(3'b100, 7'h06, 1);
    @(negedge clk);
    enable = 3'b000; segmentos = 7'h00;
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: valid=%b one edge after C, required 0", valid);
    end
    @(negedge clk);
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: valid=%b two edges after C, required 1", valid);
    end
    drive(3'b000, 7'h00, 2);
    check_outs("basic_outputs", 4, 3, 1);
  endtask

  task automatic test_hold();
    frame(4, 3, 1, 5, 1'b0);
    frame(7, 0, 9, 5, 1'b0);
    frame(2, 5, 8, 5, 1'b0);
    check_outs("hold_outputs", 2, 5, 8);
  endtask

  task automatic test_skip();
    drive(3'b001, seg_of(6), 1);
    sb.push_back(exp_err());
    drive(3'b100, seg_of(6), 1);
    drive(3'b000, 7'h00, 3);
    check_outs("skip_outputs", 2, 5, 8);
  endtask

  task automatic test_bad_pattern();
    frame(4, 3, 1, 1, 1'b0);
    frame(4, 9, 1, 2, 1'b1);
    check_outs("bad_keeps", 4, 3, 1);
    frame(-1, -1, 7, 1, 1'b0);
    check_outs("blank_publish", -1, -1, 7);
    frame(6, 2, 0, 1, 1'b0);
    check_outs("good_after_bad", 6, 2, 0);
  endtask

  task automatic test_onehot_and_reset();
    drive(3'b001, seg_of(3), 1);
    sb.push_back(exp_err());
    drive(3'b011, seg_of(3), 1);
    drive(3'b010, seg_of(3), 1);
    drive(3'b100, seg_of(3), 1);
    drive(3'b000, 7'h00, 3);
    check_outs("onehot_keeps", 6, 2, 0);
    drive(3'b001, seg_of(1), 1);
    drive(3'b010, seg_of(2), 1);
    drive(3'b000, 7'h00, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outs("midframe_reset", -1, -1, -1);
    drive(3'b100, seg_of(3), 2);
    drive(3'b000, 7'h00, 3);
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_valid: valid=%b, required 0", valid);
    end
    frame(9, 8, 7, 1, 1'b0);
    check_outs("after_reset_frame", 9, 8, 7);
  endtask

  task automatic test_timeout();
    drive(3'b001, seg_of(1), 1);
`ifdef RX_DISPLAY_TIMEOUT_EN
    sb.push_back(exp_err());
`endif
    drive(3'b010, seg_of(2), 70);
`ifndef RX_DISPLAY_TIMEOUT_EN
    sb.push_back(exp_valid(1, 2, 3));
`endif
    drive(3'b100, seg_of(3), 1);
    drive(3'b000, 7'h00, 3);
`ifdef RX_DISPLAY_TIMEOUT_EN
    check_outs("timeout_keeps", 9, 8, 7);
`else
    check_outs("stall_publish", 1, 2, 3);
`endif
    frame(5, 6, 7, 1, 1'b0);
    check_outs("post_stall_frame", 5, 6, 7);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_skip();
    test_bad_pattern();
    test_onehot_and_reset();
    test_timeout();
    repeat (5) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_pulses: %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
